// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for the adaptive_filter datapath and its control front-end.
package adaptive_filter_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        WARMUP = 2'd3
    } af_ctrl_state_t;

    localparam logic AF_MODE_DIFF   = 1'b0;
    localparam logic AF_MODE_INTEGR = 1'b1;

endpackage

// File: rtl/adaptive_filter_ctrl.sv
// Mode-switch sequencer: drains, flushes and re-warms adaptive_filter on every effective mode change.
// Sample path latency 2 cycles; upstream stalled for 1+FLUSH_CYCLES cycles per mode change.
module adaptive_filter_ctrl
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_WIDTH     = 14,
    parameter int FLUSH_CYCLES   = 2,
    parameter int WARMUP_SAMPLES = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  mode_req,
    input  logic                  mode_req_valid,
    output logic                  mode_req_ready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  f_srst,
    output logic                  f_ctrl,
    output logic [DATA_WIDTH-1:0] f_s_tdata,
    output logic                  f_s_tvalid,
    input  logic [DATA_WIDTH-1:0] f_m_tdata,
    input  logic                  f_m_tvalid,
    output logic                  mode_cur,
    output logic                  busy
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = (WARMUP_SAMPLES > 0) ? $clog2(WARMUP_SAMPLES + 1) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WARM_LAST  = WW'((WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0);
    localparam af_ctrl_state_t RESET_STATE = (WARMUP_SAMPLES == 0) ? RUN : WARMUP;

    af_ctrl_state_t          r_state;
    af_ctrl_state_t          w_next_state;
    logic                    r_pend_mode;
    logic                    r_ctrl;
    logic [FW-1:0]           r_flush_cnt;
    logic [WW-1:0]           r_warm_cnt;
    logic                    r_m_tvalid;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic                    w_s_tready;
    logic                    w_req_rdy;
    logic                    w_mode_chg;
    logic                    w_out_en;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_s_tready   = 1'b0;
        w_req_rdy    = 1'b0;
        w_mode_chg   = 1'b0;
        case (r_state)
            RUN: begin
                w_s_tready = 1'b1;
                w_req_rdy  = 1'b1;
                // A same-mode request is simply acknowledged and has no effect.
                if (mode_req_valid && (mode_req != r_ctrl)) begin
                    w_mode_chg   = 1'b1;
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = FLUSH;
            end
            FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_next_state = (WARMUP_SAMPLES == 0) ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                w_s_tready = 1'b1;
                if (f_m_tvalid && (r_warm_cnt == WARM_LAST)) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RESET_STATE;
            end
        endcase
    end

    // DRAIN still forwards, so the last old-mode output survives the switch.
    assign w_out_en = (r_state == RUN) || (r_state == DRAIN);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_pend_mode <= AF_MODE_DIFF;
            r_ctrl      <= AF_MODE_DIFF;
            r_flush_cnt <= '0;
            r_warm_cnt  <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tdata   <= '0;
        end else begin
            if (w_mode_chg) begin
                r_pend_mode <= mode_req;
            end
            if (r_state == DRAIN) begin
                r_ctrl <= r_pend_mode;
            end
            if (r_state == FLUSH) begin
                r_flush_cnt <= (r_flush_cnt == FLUSH_LAST) ? '0 : r_flush_cnt + FW'(1);
            end
            if ((r_state == WARMUP) && f_m_tvalid) begin
                r_warm_cnt <= (r_warm_cnt == WARM_LAST) ? '0 : r_warm_cnt + WW'(1);
            end
            r_m_tvalid <= f_m_tvalid & w_out_en;
            if (f_m_tvalid && w_out_en) begin
                r_m_tdata <= f_m_tdata;
            end
        end
    end

    assign s_tready       = w_s_tready;
    assign mode_req_ready = w_req_rdy;
    assign f_srst         = srst | (r_state == FLUSH);
    assign f_ctrl         = r_ctrl;
    assign mode_cur       = r_ctrl;
    assign f_s_tdata      = s_tdata;
    assign f_s_tvalid     = s_tvalid & w_s_tready;
    assign m_tvalid       = r_m_tvalid;
    assign m_tdata        = r_m_tdata;
    assign busy           = (r_state != RUN);

endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// Directed bench for adaptive_filter_ctrl with a 1-cycle filter stand-in (output = input + f_ctrl).
module tb_adaptive_filter_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic        mode_req;
    logic        mode_req_valid;
    logic        mode_req_ready;
    logic [13:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [13:0] m_tdata;
    logic        m_tvalid;
    logic        f_srst;
    logic        f_ctrl;
    logic [13:0] f_s_tdata;
    logic        f_s_tvalid;
    logic [13:0] f_m_tdata;
    logic        f_m_tvalid;
    logic        mode_cur;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    adaptive_filter_ctrl #(
        .DATA_WIDTH    (14),
        .FLUSH_CYCLES  (2),
        .WARMUP_SAMPLES(10)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .mode_req      (mode_req),
        .mode_req_valid(mode_req_valid),
        .mode_req_ready(mode_req_ready),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .f_srst        (f_srst),
        .f_ctrl        (f_ctrl),
        .f_s_tdata     (f_s_tdata),
        .f_s_tvalid    (f_s_tvalid),
        .f_m_tdata     (f_m_tdata),
        .f_m_tvalid    (f_m_tvalid),
        .mode_cur      (mode_cur),
        .busy          (busy)
    );

    // Filter stand-in: latency 1, mode visible in the data so old/new-mode outputs are distinguishable.
    always @(posedge clk) begin
        if (f_srst) begin
            f_m_tvalid <= 1'b0;
            f_m_tdata  <= '0;
        end else begin
            f_m_tvalid <= f_s_tvalid;
            f_m_tdata  <= f_s_tdata + {13'd0, f_ctrl};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          n_pulse;
    int          first_at;
    logic [13:0] first_dat;
    int          wait_cyc;

    initial begin
        srst = 1'b1; mode_req = 1'b0; mode_req_valid = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0;
        tick(); tick();
        chk("rst_f_srst",   f_srst, 1);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata",  m_tdata, 0);
        chk("rst_f_ctrl",   f_ctrl, 0);
        chk("rst_s_tready", s_tready, 1);
        chk("rst_req_rdy",  mode_req_ready, 0);
        chk("rst_busy",     busy, 1);
        srst = 1'b0;
        #1 chk("rel_f_srst", f_srst, 0);

        // Warm-up after reset: outputs 1..10 dropped, 11 and 12 forwarded.
        for (int i = 0; i < 14; i++) begin
            s_tvalid = (i < 12);
            s_tdata  = 14'h0040;
            tick();
            chk($sformatf("wu_vld_%0d", i), m_tvalid, (i == 11 || i == 12));
            chk($sformatf("wu_busy_%0d", i), busy, (i < 10));
        end
        chk("wu_dat", m_tdata, 14'h0040);

        // Effective mode change with a sample in the same cycle.
        chk("mc_req_rdy_run", mode_req_ready, 1);
        s_tvalid = 1'b1; s_tdata = 14'h0100; mode_req = 1'b1; mode_req_valid = 1'b1;
        #1 chk("mc_f_s_tvalid", f_s_tvalid, 1);
        chk("mc_f_s_tdata", f_s_tdata, 14'h0100);
        tick();
        mode_req_valid = 1'b0;
        #1 chk("drain_f_s_tvalid", f_s_tvalid, 0);
        chk("drain_s_tready", s_tready, 0);
        chk("drain_req_rdy",  mode_req_ready, 0);
        chk("drain_f_srst",   f_srst, 0);
        chk("drain_f_ctrl",   f_ctrl, 0);
        chk("drain_busy",     busy, 1);
        s_tvalid = 1'b0;
        tick();
        chk("fl1_m_tvalid", m_tvalid, 1);
        chk("fl1_m_tdata",  m_tdata, 14'h0100);
        chk("fl1_f_srst",   f_srst, 1);
        chk("fl1_f_ctrl",   f_ctrl, 1);
        chk("fl1_mode_cur", mode_cur, 1);
        chk("fl1_s_tready", s_tready, 0);
        tick();
        chk("fl2_f_srst",   f_srst, 1);
        chk("fl2_s_tready", s_tready, 0);
        chk("fl2_m_tvalid", m_tvalid, 0);
        tick();
        chk("wu2_s_tready", s_tready, 1);
        chk("wu2_f_srst",   f_srst, 0);
        chk("wu2_busy",     busy, 1);
        chk("wu2_req_rdy",  mode_req_ready, 0);

        // Gapped samples during warm-up: only f_m_tvalid advances the counter.
        n_pulse = 0; first_at = -1; first_dat = '0;
        for (int n = 0; n < 39; n++) begin
            s_tvalid = ((n % 3) == 0) && (n < 36);
            s_tdata  = 14'h0200 + 14'(n / 3);
            tick();
            if (m_tvalid) begin
                if (n_pulse == 0) begin
                    first_at = n;
                    first_dat = m_tdata;
                end
                n_pulse++;
            end
        end
        chk("gap_pulses",   n_pulse, 2);
        chk("gap_first_at", first_at, 31);
        chk("gap_first_dat", first_dat, 14'h020B);
        chk("gap_last_dat", m_tdata, 14'h020C);
        chk("gap_busy",     busy, 0);

        // Same-mode request: no-op, stream uninterrupted.
        for (int k = 0; k < 5; k++) begin
            s_tvalid = (k < 3);
            s_tdata  = 14'h0300 + 14'(k);
            mode_req = 1'b1;
            mode_req_valid = (k == 0);
            if (k == 0) chk("noop_req_rdy", mode_req_ready, 1);
            tick();
            chk($sformatf("noop_s_tready_%0d", k), s_tready, 1);
            chk($sformatf("noop_f_srst_%0d", k), f_srst, 0);
            chk($sformatf("noop_vld_%0d", k), m_tvalid, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk($sformatf("noop_dat_%0d", k), m_tdata, 14'h0300 + k);
        end
        mode_req_valid = 1'b0;

        // Request held through DRAIN/FLUSH/WARMUP: ready only on the first RUN cycle.
        mode_req = 1'b0; mode_req_valid = 1'b1;
        s_tvalid = 1'b1; s_tdata = 14'h0350;
        chk("hold_rdy_run", mode_req_ready, 1);
        tick();
        wait_cyc = 1;
        while (!mode_req_ready && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        chk("hold_first_rdy", wait_cyc, 15);
        chk("hold_f_ctrl", f_ctrl, 0);
        tick();
        chk("hold_noop_busy", busy, 0);
        chk("hold_noop_f_srst", f_srst, 0);
        mode_req_valid = 1'b0; s_tvalid = 1'b0;
        tick(); tick(); tick();

        // srst during FLUSH discards the pending mode and restarts warm-up.
        mode_req = 1'b1; mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        tick();
        chk("sf_f_srst", f_srst, 1);
        chk("sf_f_ctrl", f_ctrl, 1);
        srst = 1'b1;
        tick();
        chk("sr_f_ctrl",   f_ctrl, 0);
        chk("sr_m_tvalid", m_tvalid, 0);
        chk("sr_busy",     busy, 1);
        chk("sr_s_tready", s_tready, 1);
        chk("sr_req_rdy",  mode_req_ready, 0);
        srst = 1'b0;
        n_pulse = 0; first_at = -1; first_dat = '0;
        for (int n = 0; n < 16; n++) begin
            s_tvalid = (n < 12);
            s_tdata  = 14'h0400 + 14'(n);
            tick();
            if (m_tvalid) begin
                if (n_pulse == 0) begin
                    first_at = n;
                    first_dat = m_tdata;
                end
                n_pulse++;
            end
        end
        chk("sr_pulses",    n_pulse, 2);
        chk("sr_first_at",  first_at, 11);
        chk("sr_first_dat", first_dat, 14'h040A);
        chk("sr_mode_cur",  mode_cur, 0);
        chk("sr_end_busy",  busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
